// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared state encoding and register-file widths for the RF port arbiter
package rf_arb_pkg;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  typedef enum logic [2:0] {ST_RUN, ST_DRAIN, ST_HALTED, ST_ACCESS, ST_ACK} rf_arb_state_t;
endpackage

// File: rtl/rf_port_arbiter_if.sv
// rf_port_arbiter_if: CPU writeback/RS1, debug request/response and REG_FILE port bundle; master = CPU/debug/REG_FILE side, slave = arbiter
interface rf_port_arbiter_if #(parameter int DROP_CNT_W = 8);
  logic                             CPU_WR_EN;
  logic [rf_arb_pkg::RF_ADDR_W-1:0] CPU_WR_ADDR;
  logic [rf_arb_pkg::RF_DATA_W-1:0] CPU_WR_DATA;
  logic [rf_arb_pkg::RF_ADDR_W-1:0] CPU_ADDR1;
  logic                             CPU_STALL;
  logic                             DBG_HALT;
  logic                             DBG_REQ;
  logic                             DBG_WE;
  logic [rf_arb_pkg::RF_ADDR_W-1:0] DBG_ADDR;
  logic [rf_arb_pkg::RF_DATA_W-1:0] DBG_WDATA;
  logic                             DBG_ACK;
  logic [rf_arb_pkg::RF_DATA_W-1:0] DBG_RDATA;
  logic                             HALTED;
  logic [DROP_CNT_W-1:0]            DROP_CNT;
  logic                             RF_WR_EN;
  logic [rf_arb_pkg::RF_ADDR_W-1:0] RF_WR_ADDR;
  logic [rf_arb_pkg::RF_DATA_W-1:0] RF_WR_DATA;
  logic [31:0]                      RF_ADDR1;
  logic [rf_arb_pkg::RF_DATA_W-1:0] RF_RS1;
  modport master (
    output CPU_WR_EN, CPU_WR_ADDR, CPU_WR_DATA, CPU_ADDR1, DBG_HALT, DBG_REQ, DBG_WE, DBG_ADDR, DBG_WDATA, RF_RS1,
    input  CPU_STALL, DBG_ACK, DBG_RDATA, HALTED, DROP_CNT, RF_WR_EN, RF_WR_ADDR, RF_WR_DATA, RF_ADDR1
  );
  modport slave (
    input  CPU_WR_EN, CPU_WR_ADDR, CPU_WR_DATA, CPU_ADDR1, DBG_HALT, DBG_REQ, DBG_WE, DBG_ADDR, DBG_WDATA, RF_RS1,
    output CPU_STALL, DBG_ACK, DBG_RDATA, HALTED, DROP_CNT, RF_WR_EN, RF_WR_ADDR, RF_WR_DATA, RF_ADDR1
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones; clk/rst clear, i_inc steps, o_cnt value
module sat_counter #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk)
    if (rst) r_cnt <= '0;
    else if (i_inc && !(&r_cnt)) r_cnt <= r_cnt + W'(1);
  assign o_cnt = r_cnt;
endmodule

// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: muxes REG_FILE write port and ADDR1 between CPU and debug unit; CLK/RST plain, everything else on bus (slave)
module rf_port_arbiter
  import rf_arb_pkg::*;
#(parameter int DROP_CNT_W = 8) (
  input logic           CLK,
  input logic           RST,
  rf_port_arbiter_if.slave bus
);
  rf_arb_state_t          r_state, w_next;
  logic                   r_we;
  logic [RF_ADDR_W-1:0]   r_addr;
  logic [RF_DATA_W-1:0]   r_wdata, r_rdata;
  logic                   w_acc, w_park, w_cap;
  assign w_acc  = r_state == ST_ACCESS;
  assign w_park = r_state == ST_HALTED || r_state == ST_ACCESS || r_state == ST_ACK;
  assign w_cap  = bus.DBG_REQ && (r_state == ST_DRAIN || r_state == ST_HALTED);
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RUN:    w_next = (bus.DBG_REQ || bus.DBG_HALT) ? ST_DRAIN : ST_RUN;
      ST_DRAIN:  w_next = bus.DBG_REQ ? ST_ACCESS : bus.DBG_HALT ? ST_HALTED : ST_RUN;
      ST_HALTED: w_next = bus.DBG_REQ ? ST_ACCESS : bus.DBG_HALT ? ST_HALTED : ST_RUN;
      ST_ACCESS: w_next = ST_ACK;
      ST_ACK:    w_next = bus.DBG_HALT ? ST_HALTED : ST_RUN;
      default:   w_next = ST_RUN;
    endcase
  end
  always_ff @(posedge CLK)
    if (RST) begin
      r_state <= ST_RUN;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_cap) begin
        r_we    <= bus.DBG_WE;
        r_addr  <= bus.DBG_ADDR;
        r_wdata <= bus.DBG_WDATA;
      end
      if (w_acc && !r_we) r_rdata <= bus.RF_RS1;
    end
  sat_counter #(.W(DROP_CNT_W)) u_drop (
    .clk   (CLK),
    .rst   (RST),
    .i_inc (w_park && bus.CPU_WR_EN),
    .o_cnt (bus.DROP_CNT)
  );
  assign bus.CPU_STALL  = r_state != ST_RUN;
  assign bus.HALTED     = r_state == ST_HALTED;
  assign bus.DBG_ACK    = r_state == ST_ACK;
  assign bus.DBG_RDATA  = r_rdata;
  // CPU owns the write port only in RUN/DRAIN; reset gates any write away from REG_FILE
  assign bus.RF_WR_EN   = (w_acc ? r_we && |r_addr : !w_park && bus.CPU_WR_EN) && !RST;
  assign bus.RF_WR_ADDR = w_acc ? r_addr : bus.CPU_WR_ADDR;
  assign bus.RF_WR_DATA = w_acc ? r_wdata : bus.CPU_WR_DATA;
  assign bus.RF_ADDR1   = {27'd0, w_acc ? r_addr : bus.CPU_ADDR1};
endmodule

// File: tb/tb_rf_port_arbiter.sv
// tb_rf_port_arbiter: directed checks of the RF port arbiter against a REG_FILE stub
module tb_rf_port_arbiter;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rf [32];
  rf_port_arbiter_if #(.DROP_CNT_W(8)) bus ();
  rf_port_arbiter #(.DROP_CNT_W(8)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  always @(posedge CLK) if (bus.RF_WR_EN) rf[bus.RF_WR_ADDR] <= bus.RF_WR_DATA;
  assign bus.RF_RS1 = rf[bus.RF_ADDR1[4:0]];
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    int bad;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    bus.CPU_WR_EN = 1'b1; bus.CPU_WR_ADDR = 5'd4; bus.CPU_WR_DATA = 32'h44; bus.CPU_ADDR1 = 5'd0;
    bus.DBG_HALT = 1'b0; bus.DBG_REQ = 1'b0; bus.DBG_WE = 1'b0; bus.DBG_ADDR = 5'd0; bus.DBG_WDATA = 32'd0;
    tick(); tick();
    #1;
    chk("rst_stall", 32'(bus.CPU_STALL), 32'd0);
    chk("rst_halted", 32'(bus.HALTED), 32'd0);
    chk("rst_ack", 32'(bus.DBG_ACK), 32'd0);
    chk("rst_rdata", bus.DBG_RDATA, 32'd0);
    chk("rst_drop", 32'(bus.DROP_CNT), 32'd0);
    chk("rst_wr_gated", 32'(bus.RF_WR_EN), 32'd0);
    RST = 1'b0;
    tick();
    bus.CPU_WR_EN = 1'b1; bus.CPU_WR_ADDR = 5'd5; bus.CPU_WR_DATA = 32'h1234;
    #1;
    chk("run_wr_en", 32'(bus.RF_WR_EN), 32'd1);
    chk("run_wr_addr", 32'(bus.RF_WR_ADDR), 32'd5);
    chk("run_wr_data", bus.RF_WR_DATA, 32'h1234);
    chk("run_stall", 32'(bus.CPU_STALL), 32'd0);
    tick();
    bus.CPU_WR_EN = 1'b0;
    bus.DBG_REQ = 1'b1; bus.DBG_WE = 1'b1; bus.DBG_ADDR = 5'd7; bus.DBG_WDATA = 32'hDEADBEEF;
    #1;
    chk("req0_stall", 32'(bus.CPU_STALL), 32'd0);
    chk("x5_written", rf[5], 32'h1234);
    tick();
    bus.CPU_WR_EN = 1'b1; bus.CPU_WR_ADDR = 5'd3; bus.CPU_WR_DATA = 32'h33;
    #1;
    chk("drain_stall", 32'(bus.CPU_STALL), 32'd1);
    chk("drain_wr_en", 32'(bus.RF_WR_EN), 32'd1);
    chk("drain_wr_addr", 32'(bus.RF_WR_ADDR), 32'd3);
    tick();
    bus.CPU_WR_EN = 1'b0;
    #1;
    chk("acc_wr_en", 32'(bus.RF_WR_EN), 32'd1);
    chk("acc_wr_addr", 32'(bus.RF_WR_ADDR), 32'd7);
    chk("acc_wr_data", bus.RF_WR_DATA, 32'hDEADBEEF);
    chk("acc_ack", 32'(bus.DBG_ACK), 32'd0);
    chk("x3_written", rf[3], 32'h33);
    tick();
    bus.DBG_REQ = 1'b0;
    #1;
    chk("ack_pulse", 32'(bus.DBG_ACK), 32'd1);
    chk("ack_stall", 32'(bus.CPU_STALL), 32'd1);
    chk("ack_wr_en", 32'(bus.RF_WR_EN), 32'd0);
    chk("x7_written", rf[7], 32'hDEADBEEF);
    tick();
    bus.DBG_HALT = 1'b1;
    #1;
    chk("resume_stall", 32'(bus.CPU_STALL), 32'd0);
    chk("resume_ack", 32'(bus.DBG_ACK), 32'd0);
    tick();
    #1;
    chk("hdrain_stall", 32'(bus.CPU_STALL), 32'd1);
    chk("hdrain_halted", 32'(bus.HALTED), 32'd0);
    tick();
    bus.DBG_REQ = 1'b1; bus.DBG_WE = 1'b0; bus.DBG_ADDR = 5'd7;
    #1;
    chk("halted", 32'(bus.HALTED), 32'd1);
    tick();
    #1;
    chk("rd_acc_addr1", bus.RF_ADDR1, 32'd7);
    chk("rd_acc_halted", 32'(bus.HALTED), 32'd0);
    chk("rd_acc_wr_en", 32'(bus.RF_WR_EN), 32'd0);
    tick();
    bus.DBG_REQ = 1'b0;
    #1;
    chk("rd_ack", 32'(bus.DBG_ACK), 32'd1);
    chk("rd_rdata", bus.DBG_RDATA, 32'hDEADBEEF);
    tick();
    bus.CPU_WR_EN = 1'b1; bus.CPU_WR_ADDR = 5'd6; bus.CPU_WR_DATA = 32'h66;
    #1;
    chk("rd_back_halted", 32'(bus.HALTED), 32'd1);
    chk("rd_back_ack", 32'(bus.DBG_ACK), 32'd0);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (bus.RF_WR_EN !== 1'b0) bad++;
      tick();
      #1;
      if (i == 9) chk("drop_10", 32'(bus.DROP_CNT), 32'd10);
    end
    chk("halt_no_wr", 32'(bad), 32'd0);
    chk("drop_sat", 32'(bus.DROP_CNT), 32'd255);
    chk("x6_unwritten", rf[6], 32'd0);
    bus.CPU_WR_EN = 1'b0;
    bus.DBG_REQ = 1'b1; bus.DBG_WE = 1'b1; bus.DBG_ADDR = 5'd0; bus.DBG_WDATA = 32'hFFFFFFFF;
    tick();
    #1;
    chk("x0_acc_wr_en", 32'(bus.RF_WR_EN), 32'd0);
    tick();
    bus.DBG_REQ = 1'b0;
    #1;
    chk("x0_ack", 32'(bus.DBG_ACK), 32'd1);
    chk("x0_ack_wr_en", 32'(bus.RF_WR_EN), 32'd0);
    tick();
    bus.DBG_REQ = 1'b1; bus.DBG_WE = 1'b0; bus.DBG_ADDR = 5'd0;
    tick();
    tick();
    bus.DBG_REQ = 1'b0;
    #1;
    chk("x0_rd_ack", 32'(bus.DBG_ACK), 32'd1);
    chk("x0_rd_data", bus.DBG_RDATA, 32'd0);
    tick();
    bus.DBG_HALT = 1'b0;
    tick();
    bus.DBG_REQ = 1'b1; bus.DBG_WE = 1'b1; bus.DBG_ADDR = 5'd9; bus.DBG_WDATA = 32'h99;
    #1;
    chk("x9_run_stall", 32'(bus.CPU_STALL), 32'd0);
    tick();
    tick();
    #1;
    chk("x9_acc_wr_en", 32'(bus.RF_WR_EN), 32'd1);
    chk("x9_acc_addr", 32'(bus.RF_WR_ADDR), 32'd9);
    RST = 1'b1;
    #1;
    chk("x9_rst_wr_en", 32'(bus.RF_WR_EN), 32'd0);
    tick();
    RST = 1'b0; bus.DBG_REQ = 1'b0;
    #1;
    chk("abort_ack", 32'(bus.DBG_ACK), 32'd0);
    chk("abort_stall", 32'(bus.CPU_STALL), 32'd0);
    chk("abort_halted", 32'(bus.HALTED), 32'd0);
    chk("abort_rdata", bus.DBG_RDATA, 32'd0);
    chk("abort_drop", 32'(bus.DROP_CNT), 32'd0);
    chk("x9_unwritten", rf[9], 32'd0);
    tick();
    #1;
    chk("abort_run_stall", 32'(bus.CPU_STALL), 32'd0);
    chk("abort_run_ack", 32'(bus.DBG_ACK), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
